// File: rtl/sprite_row_fetch.sv
// Fetches one 16-pixel row of an 8-bpp sprite from the sprite ROM (two pixels per word)
// and writes it into the scanline buffer with transparency, horizontal flip and right-edge clipping.
module sprite_row_fetch #(
    parameter int unsigned LINE_WIDTH  = 640,
    parameter logic [7:0]  TRANSPARENT = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  row,
    input  logic [9:0]  x_pos,
    input  logic        hflip,
    input  logic        lb_stall,
    output logic        busy,
    output logic        done,
    output logic [6:0]  rom_addr,
    output logic        rom_clken,
    input  logic [15:0] rom_rddata,
    output logic        lb_we,
    output logic [9:0]  lb_addr,
    output logic [7:0]  lb_wdata
);

    localparam logic [10:0] LineLimit = 11'(LINE_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        LO,
        HI
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  word_q, word_d;
    logic [9:0]  xpos_q, xpos_d;
    logic        hflip_q, hflip_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [6:0]  rom_addr_q, rom_addr_d;

    logic        emitting;
    logic [3:0]  pix_idx;
    logic [3:0]  col_off;
    logic [10:0] sum;
    logic [7:0]  pixel;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        xpos_d     = xpos_q;
        hflip_d    = hflip_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rom_addr_d = rom_addr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = PRIME;
                    xpos_d     = x_pos;
                    hflip_d    = hflip;
                    rom_addr_d = {row, 3'd0};
                    word_d     = 3'd0;
                    busy_d     = 1'b1;
                end
            end
            PRIME: begin
                if (!lb_stall) begin
                    state_d = LO;
                end
            end
            LO: begin
                // The ROM samples the new address at the end of HI, so HI still sees this word.
                if (!lb_stall) begin
                    state_d    = HI;
                    rom_addr_d = {rom_addr_q[6:3], word_q + 3'd1};
                end
            end
            HI: begin
                if (!lb_stall) begin
                    if (word_q == 3'd7) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LO;
                        word_d  = word_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            word_q     <= 3'd0;
            xpos_q     <= 10'd0;
            hflip_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rom_addr_q <= 7'd0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            xpos_q     <= xpos_d;
            hflip_q    <= hflip_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    // Sum is 11 bits so that positions past 1023 clip instead of wrapping into the visible line.
    always_comb begin
        emitting = (state_q == LO) || (state_q == HI);
        pix_idx  = {word_q, state_q == HI};
        col_off  = hflip_q ? ~pix_idx : pix_idx;
        sum      = {1'b0, xpos_q} + {7'd0, col_off};
        pixel    = (state_q == HI) ? rom_rddata[15:8] : rom_rddata[7:0];
        lb_we    = emitting && !lb_stall && (sum < LineLimit) && (pixel != TRANSPARENT);
        lb_addr  = emitting ? sum[9:0] : 10'd0;
        lb_wdata = emitting ? pixel : 8'd0;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rom_addr  = rom_addr_q;
    assign rom_clken = !(busy_q && lb_stall);

endmodule

// File: tb/tb_sprite_row_fetch.sv
// Table-driven bench for sprite_row_fetch: a behavioural ROM, an expected-write scoreboard
// queue filled from a reference model, and per-cycle checks of busy/done/rom_clken.
module tb_sprite_row_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  row;
    logic [9:0]  x_pos;
    logic        hflip;
    logic        lb_stall;
    logic        busy;
    logic        done;
    logic [6:0]  rom_addr;
    logic        rom_clken;
    logic [15:0] rom_q = 16'd0;
    logic        lb_we;
    logic [9:0]  lb_addr;
    logic [7:0]  lb_wdata;

    logic [15:0] rom_mem [128];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] row;
        logic [9:0] x_pos;
        logic       hflip;
        int         rom_kind;
        int         stall_start;
        int         stall_len;
        int         extra_start;
        int         exp_writes;
        int         exp_done;
    } vec_t;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    vec_t vecs [8];
    wr_t  exp_q [$];

    sprite_row_fetch dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .row        (row),
        .x_pos      (x_pos),
        .hflip      (hflip),
        .lb_stall   (lb_stall),
        .busy       (busy),
        .done       (done),
        .rom_addr   (rom_addr),
        .rom_clken  (rom_clken),
        .rom_rddata (rom_q),
        .lb_we      (lb_we),
        .lb_addr    (lb_addr),
        .lb_wdata   (lb_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_clken) rom_q <= rom_mem[rom_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Other rows get filler so a wrong row address shows up as wrong pixel data.
    task automatic loadRom(input int kind, input logic [3:0] r);
        logic [6:0] a;
        for (int i = 0; i < 128; i++) rom_mem[i] = 16'hA5C3 ^ 16'(i);
        for (int k = 0; k < 8; k++) begin
            a = {r, 3'(k)};
            case (kind)
                1:       rom_mem[a] = (k == 0) ? 16'h0500 : 16'(16'h0201 + k * 16'h0202);
                2:       rom_mem[a] = 16'hFFFF;
                default: rom_mem[a] = 16'(16'h0201 + k * 16'h0202);
            endcase
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx, input int reset_at);
        int         done_off;
        int         last_off;
        int         writes;
        int         cyc;
        int         c;
        int         s;
        logic [15:0] w;
        logic [7:0] px;
        logic       exp_busy;
        wr_t        e;

        loadRom(v.rom_kind, v.row);
        exp_q.delete();
        for (int p = 0; p < 16; p++) begin
            w   = rom_mem[{v.row, 3'(p / 2)}];
            px  = (p % 2 == 1) ? w[15:8] : w[7:0];
            c   = v.hflip ? 15 - p : p;
            s   = int'(v.x_pos) + c;
            cyc = 2 + p;
            if (v.stall_len > 0 && cyc >= v.stall_start) cyc += v.stall_len;
            if (s < 640 && px != 8'h00 && (reset_at == 0 || cyc < reset_at)) begin
                e.addr = s[9:0];
                e.data = px;
                e.cyc  = cyc;
                exp_q.push_back(e);
            end
        end

        done_off = (reset_at > 0) ? -1 : v.exp_done;
        last_off = (reset_at > 0) ? reset_at + 6 : v.exp_done + 3;
        writes   = 0;

        for (int off = 0; off <= last_off; off++) begin
            @(posedge clk);
            #1;
            if (off == 0) begin
                start = 1'b1;
                row   = v.row;
                x_pos = v.x_pos;
                hflip = v.hflip;
            end else begin
                start = (off == v.extra_start);
                row   = 4'd0;
                x_pos = 10'd0;
                hflip = ~v.hflip;
            end
            lb_stall = (v.stall_len > 0 && off >= v.stall_start && off < v.stall_start + v.stall_len);
            if (reset_at > 0) reset_n = !(off >= reset_at && off < reset_at + 2);
            @(negedge clk);

            exp_busy = (reset_at > 0) ? (off >= 1 && off < reset_at) : (off >= 1 && off < done_off);
            if (lb_we) begin
                writes++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL v%0d unexpected write @%0d: addr %0d data %0h, expected no write",
                             idx, off, lb_addr, lb_wdata);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput($sformatf("v%0d lb_addr@%0d", idx, off), 32'(lb_addr), 32'(e.addr));
                    checkOutput($sformatf("v%0d lb_wdata@%0d", idx, off), 32'(lb_wdata), 32'(e.data));
                    checkOutput($sformatf("v%0d write cycle", idx), 32'(off), 32'(e.cyc));
                end
            end
            checkOutput($sformatf("v%0d busy@%0d", idx, off), 32'(busy), 32'(exp_busy));
            checkOutput($sformatf("v%0d done@%0d", idx, off), 32'(done), 32'(off == done_off));
            checkOutput($sformatf("v%0d rom_clken@%0d", idx, off), 32'(rom_clken), 32'(!(exp_busy && lb_stall)));
            if (reset_at > 0 && off == reset_at) begin
                checkOutput($sformatf("v%0d lb_we in reset", idx), 32'(lb_we), 32'd0);
                checkOutput($sformatf("v%0d rom_addr in reset", idx), 32'(rom_addr), 32'd0);
                checkOutput($sformatf("v%0d lb_addr in reset", idx), 32'(lb_addr), 32'd0);
                checkOutput($sformatf("v%0d lb_wdata in reset", idx), 32'(lb_wdata), 32'd0);
            end
        end
        start    = 1'b0;
        lb_stall = 1'b0;
        reset_n  = 1'b1;
        checkOutput($sformatf("v%0d write count", idx), 32'(writes), 32'(v.exp_writes));
        checkOutput($sformatf("v%0d missing writes", idx), 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vec_t r;

        vecs[0] = '{row: 4'd3,  x_pos: 10'd100,  hflip: 1'b0, rom_kind: 0, stall_start: 0, stall_len: 0, extra_start: -1, exp_writes: 16, exp_done: 18};
        vecs[1] = '{row: 4'd3,  x_pos: 10'd100,  hflip: 1'b1, rom_kind: 0, stall_start: 0, stall_len: 0, extra_start: -1, exp_writes: 16, exp_done: 18};
        vecs[2] = '{row: 4'd3,  x_pos: 10'd0,    hflip: 1'b0, rom_kind: 1, stall_start: 0, stall_len: 0, extra_start: -1, exp_writes: 15, exp_done: 18};
        vecs[3] = '{row: 4'd3,  x_pos: 10'd630,  hflip: 1'b0, rom_kind: 2, stall_start: 0, stall_len: 0, extra_start: -1, exp_writes: 10, exp_done: 18};
        vecs[4] = '{row: 4'd3,  x_pos: 10'd100,  hflip: 1'b0, rom_kind: 0, stall_start: 5, stall_len: 3, extra_start: -1, exp_writes: 16, exp_done: 21};
        vecs[5] = '{row: 4'd3,  x_pos: 10'd100,  hflip: 1'b0, rom_kind: 0, stall_start: 0, stall_len: 0, extra_start: 5,  exp_writes: 16, exp_done: 18};
        vecs[6] = '{row: 4'd15, x_pos: 10'd625,  hflip: 1'b1, rom_kind: 0, stall_start: 9, stall_len: 2, extra_start: -1, exp_writes: 15, exp_done: 20};
        vecs[7] = '{row: 4'd7,  x_pos: 10'd1023, hflip: 1'b0, rom_kind: 0, stall_start: 0, stall_len: 0, extra_start: -1, exp_writes: 0,  exp_done: 18};

        for (int i = 0; i < 128; i++) rom_mem[i] = 16'h0000;
        reset_n  = 1'b0;
        start    = 1'b0;
        row      = 4'd0;
        x_pos    = 10'd0;
        hflip    = 1'b0;
        lb_stall = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset lb_we", 32'(lb_we), 32'd0);
        checkOutput("reset rom_addr", 32'(rom_addr), 32'd0);
        checkOutput("reset lb_addr", 32'(lb_addr), 32'd0);
        checkOutput("reset lb_wdata", 32'(lb_wdata), 32'd0);
        checkOutput("reset rom_clken", 32'(rom_clken), 32'd1);
        @(posedge clk);
        #1;
        lb_stall = 1'b0;
        reset_n  = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i, 0);

        // Mid-row reset keeps only the six pixels already written, then a fresh start must behave normally.
        r = vecs[0];
        r.exp_writes = 6;
        applyStimulus(r, 8, 8);
        applyStimulus(vecs[0], 9, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
